// File: rtl/swap_timer.sv
// Programmable swap/tick timer with toggle, tick-only and one-shot modes.
// Optional SWAP_TIMER_PAUSE_EN adds a pause input that freezes a running count.
module swap_timer #(
  parameter int WIDTH      = 6,
  parameter int DEF_PERIOD = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [1:0]       mode_in,
`ifdef SWAP_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             swap,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic [1:0]       r_mode;
  logic             r_swap;
  logic             r_tick;

  logic             w_pause;
  logic             w_terminal;

`ifdef SWAP_TIMER_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Equality compare keeps count within 0..period, so no wrap path exists.
  assign w_terminal = (r_count == r_period);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_period <= WIDTH'(DEF_PERIOD);
      r_mode   <= 2'b00;
      r_swap   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (load) begin
        r_period <= period_in;
        r_mode   <= mode_in;
        r_count  <= '0;
        r_state  <= en ? S_RUN : S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_count <= '0;
            if (en) r_state <= S_RUN;
          end
          S_RUN: begin
            if (!en) begin
              r_state <= S_IDLE;
              r_count <= '0;
            end else if (!w_pause) begin
              if (w_terminal) begin
                r_count <= '0;
                r_tick  <= 1'b1;
                case (r_mode)
                  2'b01: r_swap <= r_swap;
                  2'b10: begin
                    r_swap  <= 1'b1;
                    r_state <= S_DONE;
                  end
                  default: r_swap <= ~r_swap;
                endcase
              end else begin
                r_count <= r_count + WIDTH'(1);
              end
            end
          end
          S_DONE: r_count <= '0;
          default: begin
            r_state <= S_IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign swap  = r_swap;
  assign tick  = r_tick;
  assign count = r_count;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_swap_timer.sv
// Randomised and directed bench for swap_timer against an elapsed-cycle reference model.
module tb_swap_timer;
  localparam int WIDTH      = 6;
  localparam int DEF_PERIOD = 30;
`ifdef SWAP_TIMER_PAUSE_EN
  localparam bit HAS_PAUSE = 1'b1;
`else
  localparam bit HAS_PAUSE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] period_in = '0;
  logic [1:0]       mode_in = 2'b00;
  logic             pause = 1'b0;
  logic             swap, tick, busy, done;
  logic [WIDTH-1:0] count;

  always #5 clk = ~clk;

  swap_timer #(.WIDTH(WIDTH), .DEF_PERIOD(DEF_PERIOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .period_in(period_in),
    .mode_in  (mode_in),
`ifdef SWAP_TIMER_PAUSE_EN
    .pause    (pause),
`endif
    .swap     (swap),
    .tick     (tick),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: state plus number of counting cycles since the last restart.
  int m_state;   // 0 idle, 1 run, 2 done
  int m_run;
  int m_period;
  int m_mode;
  bit m_swap;
  bit m_tick;

  int iv_expect = 0;
  int last_tick = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int m_count();
    return (m_state == 1) ? (m_run % (m_period + 1)) : 0;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_run    = 0;
    m_period = DEF_PERIOD;
    m_mode   = 0;
    m_swap   = 1'b0;
    m_tick   = 1'b0;
  endtask

  task automatic model_step();
    bit pz;
    pz = HAS_PAUSE && pause;
    m_tick = 1'b0;
    if (load) begin
      m_period = int'(period_in);
      m_mode   = int'(mode_in);
      m_run    = 0;
      m_state  = en ? 1 : 0;
    end else if (m_state == 0) begin
      m_run = 0;
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      if (!en) begin
        m_state = 0;
        m_run   = 0;
      end else if (!pz) begin
        m_run++;
        if (m_run % (m_period + 1) == 0) begin
          m_tick = 1'b1;
          if (m_mode == 2) begin
            m_swap  = 1'b1;
            m_state = 2;
            m_run   = 0;
          end else if (m_mode != 1) begin
            m_swap = ~m_swap;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(m_count()));
    check("swap",  32'(swap),  32'(m_swap));
    check("tick",  32'(tick),  32'(m_tick));
    check("busy",  32'(busy),  32'(m_state == 1));
    check("done",  32'(done),  32'(m_state == 2));
  endtask

  // One transaction: drive at the falling edge, model and compare just after the rising edge.
  task automatic step(input bit e, input bit l, input int p, input int m, input bit pz);
    en        = e;
    load      = l;
    period_in = p[WIDTH-1:0];
    mode_in   = m[1:0];
    pause     = pz;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_outputs();
    if (iv_expect > 0 && tick === 1'b1) begin
      if (last_tick >= 0) check("interval", 32'(cyc - last_tick), 32'(iv_expect));
      last_tick = cyc;
    end
    $display("cyc=%0d en=%0b load=%0b pin=%0d mode=%0d pause=%0b | count=%0d swap=%0b tick=%0b busy=%0b done=%0b",
             cyc, e, l, p, m, pz, count, swap, tick, busy, done);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    $display("cyc=%0d async reset | count=%0d swap=%0b tick=%0b busy=%0b done=%0b",
             cyc, count, swap, tick, busy, done);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_interval(input int iv);
    iv_expect = iv;
    last_tick = -1;
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Default period after reset: 31-cycle toggle interval.
    set_interval(DEF_PERIOD + 1);
    for (int i = 0; i < 70; i++) step(1, 0, 0, 0, 0);

    // Reload mid-run at count 12.
    for (int i = 0; i < 64 && m_count() != 12; i++) step(1, 0, 0, 0, 0);
    check("reach12", 32'(count), 32'd12);
    set_interval(5);
    step(1, 1, 4, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0);

    // Tick-only mode.
    set_interval(3);
    step(1, 1, 2, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);

    // One-shot, then en toggling must not leave DONE.
    set_interval(0);
    step(1, 1, 3, 2, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(i[0], 0, 0, 0, 0);

    // Period zero: tick every cycle, swap alternates.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);

    // Drop en mid-count, then resume.
    step(1, 1, 9, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

    if (HAS_PAUSE) begin
      step(1, 1, 5, 0, 0);
      for (int i = 0; i < 16 && m_count() != 3; i++) step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
    end

    // Async reset between edges with non-trivial state.
    step(1, 1, 7, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
    async_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bit l, e, pz;
      int p, m;
      l  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 9) != 0);
      p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      m  = int'($urandom_range(0, 3));
      pz = HAS_PAUSE && ($urandom_range(0, 4) == 0);
      step(e, l, p, m, pz);
      if (i % 150 == 149) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
